// File: rtl/microwave_pkg.sv
// Shared definitions for the microwave subsystem: mode encodings driven by the
// control FSM and the bus widths used by the timer.
package microwave_pkg;

  localparam int unsigned MODE_W = 3;
  localparam int unsigned TIME_W = 14;
  localparam int unsigned MIN_W  = 7;
  localparam int unsigned SEC_W  = 6;

  // Control FSM state as seen by the timer; unlisted codes behave as IDLE.
  typedef enum logic [MODE_W-1:0] {
    MODE_IDLE   = 3'b000,
    MODE_SET    = 3'b001,
    MODE_RUN    = 3'b010,
    MODE_STOP   = 3'b011,
    MODE_FINISH = 3'b100
  } mode_e;

endpackage

// File: rtl/microwave_timer_if.sv
// Timer bus between the control FSM / buttons (master) and the timer (slave).
//   mode      : FSM state code
//   btnU/btnD : debounced button levels
//   run_time  : remaining/set time in seconds
//   disp_min  : run_time / 60
//   disp_sec  : run_time % 60
//   done      : one-cycle pulse on countdown reaching zero
interface microwave_timer_if;
  import microwave_pkg::*;

  logic [MODE_W-1:0] mode;
  logic              btnU;
  logic              btnD;
  logic [TIME_W-1:0] run_time;
  logic [MIN_W-1:0]  disp_min;
  logic [SEC_W-1:0]  disp_sec;
  logic              done;

  modport master (output mode, btnU, btnD,
                  input  run_time, disp_min, disp_sec, done);
  modport slave  (input  mode, btnU, btnD,
                  output run_time, disp_min, disp_sec, done);
endinterface

// File: rtl/microwave_btn_repeat.sv
// Button step generator: one step on the rising edge, one more after a half
// second hold, then one every tenth of a second while held.
//   clk, reset : clock, async active-high reset
//   enable     : steps allowed; when low the repeat counter is held at 0
//   level      : debounced button level
//   step       : one-cycle step request, same cycle as the edge/repeat point
module microwave_btn_repeat #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic level,
  output logic step
);

  localparam int unsigned HOLD_CYC   = CLK_HZ / 2;
  localparam int unsigned REPEAT_CYC = CLK_HZ / 10;
  localparam int unsigned CNT_W      = $clog2(HOLD_CYC + 1);
  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_CYC);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(HOLD_CYC - REPEAT_CYC + 1);

  logic             r_level_q;
  logic [CNT_W-1:0] r_cnt;
  logic             w_rise;
  logic             w_repeat;

  assign w_rise   = level & ~r_level_q;
  assign w_repeat = level & r_level_q & (r_cnt == HOLD_CNT);
  assign step     = enable & (w_rise | w_repeat);

  // r_cnt counts cycles since the edge; zero means "not armed", so a button
  // already held when stepping becomes enabled never auto-repeats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_level_q <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_level_q <= level;
      if (!enable || !level)      r_cnt <= '0;
      else if (w_rise)            r_cnt <= CNT_W'(1);
      else if (r_cnt == HOLD_CNT) r_cnt <= RELOAD;
      else if (r_cnt != '0)       r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/microwave_timer.sv
// Cooking-time register: edited with the buttons in SET, counted down once
// per second in RUN, split into minutes/seconds for the display.
//   clk, reset : clock, async active-high reset
//   bus        : timer bus (slave side), see microwave_timer_if
module microwave_timer
  import microwave_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned STEP_SEC = 10,
  parameter int unsigned MAX_SEC  = 5999
) (
  input  logic              clk,
  input  logic              reset,
  microwave_timer_if.slave  bus
);

  localparam int unsigned PRESC_W = $clog2(CLK_HZ);
  localparam logic [PRESC_W-1:0] PRESC_TC = PRESC_W'(CLK_HZ - 1);

  logic [PRESC_W-1:0] r_presc;
  logic [TIME_W-1:0]  r_run_time;
  logic               r_done;

  logic              w_set;
  logic              w_run;
  logic              w_btn_en;
  logic              w_step_up;
  logic              w_step_dn;
  logic              w_tick;
  logic [TIME_W:0]   w_sum;
  logic [TIME_W-1:0] w_inc;
  logic [TIME_W-1:0] w_dec;
  logic [TIME_W-1:0] w_next;

  assign w_set    = (bus.mode == MODE_SET);
  assign w_run    = (bus.mode == MODE_RUN);
  // Both buttons high cancels each other and parks both repeat counters.
  assign w_btn_en = w_set & ~(bus.btnU & bus.btnD);
  assign w_tick   = w_run & (r_presc == PRESC_TC);

  microwave_btn_repeat #(.CLK_HZ(CLK_HZ)) u_btn_up (
    .clk    (clk),
    .reset  (reset),
    .enable (w_btn_en),
    .level  (bus.btnU),
    .step   (w_step_up)
  );

  microwave_btn_repeat #(.CLK_HZ(CLK_HZ)) u_btn_dn (
    .clk    (clk),
    .reset  (reset),
    .enable (w_btn_en),
    .level  (bus.btnD),
    .step   (w_step_dn)
  );

  // Saturating step add/subtract.
  assign w_sum = {1'b0, r_run_time} + (TIME_W+1)'(STEP_SEC);
  assign w_inc = (w_sum > (TIME_W+1)'(MAX_SEC)) ? TIME_W'(MAX_SEC) : w_sum[TIME_W-1:0];
  assign w_dec = (r_run_time >= TIME_W'(STEP_SEC)) ? r_run_time - TIME_W'(STEP_SEC) : '0;

  // Next run_time per mode.
  always_comb begin
    w_next = r_run_time;
    case (bus.mode)
      MODE_SET: begin
        if (w_step_up && !w_step_dn)      w_next = w_inc;
        else if (w_step_dn && !w_step_up) w_next = w_dec;
      end
      MODE_RUN: begin
        if (w_tick && (r_run_time != '0)) w_next = r_run_time - TIME_W'(1);
      end
      MODE_STOP, MODE_FINISH: ;
      default: w_next = '0;
    endcase
  end

  // Prescaler restarts on every RUN entry, discarding partial seconds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc    <= '0;
      r_run_time <= '0;
      r_done     <= 1'b0;
    end else begin
      if (!w_run || w_tick) r_presc <= '0;
      else                  r_presc <= r_presc + PRESC_W'(1);
      r_run_time <= w_next;
      r_done     <= w_tick && (r_run_time == TIME_W'(1));
    end
  end

  assign bus.run_time = r_run_time;
  assign bus.done     = r_done;
  assign bus.disp_min = MIN_W'(r_run_time / TIME_W'(60));
  assign bus.disp_sec = SEC_W'(r_run_time % TIME_W'(60));

endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer at CLK_HZ=1000 with an expected-value queue.
module tb_microwave_timer;
  import microwave_pkg::*;

  logic clk;
  logic reset;
  microwave_timer_if bus ();

  microwave_timer #(.CLK_HZ(1000), .STEP_SEC(10), .MAX_SEC(5999)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    rt;
    bit    dn;
  } exp_t;

  exp_t q[$];
  int   n_tests;
  int   n_fail;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_v(input string tag, input int rt, input bit dn);
    exp_t e;
    e.tag = tag;
    e.rt  = rt;
    e.dn  = dn;
    q.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    logic [6:0] em;
    logic [5:0] es;
    e  = q.pop_front();
    em = 7'(e.rt / 60);
    es = 6'(e.rt % 60);
    n_tests++;
    assert (bus.run_time === 14'(e.rt)) else begin
      n_fail++;
      $error("FAIL %s run_time: got %0d expected %0d", e.tag, bus.run_time, e.rt);
    end
    n_tests++;
    assert (bus.done === e.dn) else begin
      n_fail++;
      $error("FAIL %s done: got %0b expected %0b", e.tag, bus.done, e.dn);
    end
    n_tests++;
    assert ((bus.disp_min === em) && (bus.disp_sec === es)) else begin
      n_fail++;
      $error("FAIL %s disp: got %0d:%0d expected %0d:%0d", e.tag,
             bus.disp_min, bus.disp_sec, em, es);
    end
  endtask

  task automatic chk(input string tag, input int rt, input bit dn);
    expect_v(tag, rt, dn);
    compare();
  endtask

  task automatic pulse_u();
    bus.btnU = 1'b1;
    cyc(1);
    bus.btnU = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_d();
    bus.btnD = 1'b1;
    cyc(1);
    bus.btnD = 1'b0;
    cyc(1);
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.mode = MODE_IDLE;
    bus.btnU = 1'b0;
    bus.btnD = 1'b0;
    cyc(3);
    chk("reset", 0, 1'b0);
    reset = 1'b0;
    cyc(2);

    // Set up by single steps.
    bus.mode = MODE_SET;
    cyc(1);
    bus.btnU = 1'b1; cyc(1); chk("up1", 10, 1'b0); bus.btnU = 1'b0; cyc(1);
    bus.btnU = 1'b1; cyc(1); chk("up2", 20, 1'b0); bus.btnU = 1'b0; cyc(1);
    bus.btnU = 1'b1; cyc(1); chk("up3", 30, 1'b0); bus.btnU = 1'b0; cyc(1);

    // Saturate at 99:59.
    for (int i = 0; i < 600; i++) pulse_u();
    chk("sat_max", 5999, 1'b0);

    // Count down to 5995, then step up to the limit.
    bus.mode = MODE_RUN;
    cyc(999);  chk("run_first_wait", 5999, 1'b0);
    cyc(1);    chk("run_first_dec", 5998, 1'b0);
    cyc(3000); chk("run_5995", 5995, 1'b0);
    bus.mode = MODE_SET;
    cyc(1);
    pulse_u();
    chk("sat_5995_up", 5999, 1'b0);

    // IDLE clear, then reach 5 and step down with floor.
    bus.mode = MODE_IDLE;
    cyc(1);    chk("idle_clear_a", 0, 1'b0);
    bus.mode = MODE_SET;
    cyc(1);
    pulse_u();
    bus.mode = MODE_RUN;
    cyc(5000); chk("run_to_5", 5, 1'b0);
    bus.mode = MODE_SET;
    cyc(1);
    bus.btnD = 1'b1; cyc(1); chk("dn_floor", 0, 1'b0); bus.btnD = 1'b0; cyc(1);
    pulse_d();
    chk("dn_floor2", 0, 1'b0);

    // Simultaneous edges, then held together past the repeat delay.
    pulse_u();
    chk("pre_both", 10, 1'b0);
    bus.btnU = 1'b1;
    bus.btnD = 1'b1;
    cyc(1);    chk("both_edge", 10, 1'b0);
    cyc(700);  chk("both_hold", 10, 1'b0);
    bus.btnU = 1'b0;
    bus.btnD = 1'b0;
    cyc(2);
    pulse_d();
    chk("pre_repeat", 0, 1'b0);

    // Auto-repeat: edge, +500, then every 100.
    bus.btnU = 1'b1;
    cyc(300);  chk("rep_300", 10, 1'b0);
    cyc(250);  chk("rep_550", 20, 1'b0);
    cyc(100);  chk("rep_650", 30, 1'b0);
    cyc(100);  chk("rep_750", 40, 1'b0);
    cyc(50);   chk("rep_800", 40, 1'b0);
    bus.btnU = 1'b0;
    cyc(600);  chk("rep_release", 40, 1'b0);

    // Countdown from 2 with the done pulse.
    bus.mode = MODE_IDLE;
    cyc(1);
    bus.mode = MODE_SET;
    cyc(1);
    pulse_u();
    bus.mode = MODE_RUN;
    cyc(8000); chk("cd_2", 2, 1'b0);
    cyc(999);  chk("cd_2_hold", 2, 1'b0);
    cyc(1);    chk("cd_1", 1, 1'b0);
    cyc(999);  chk("cd_1_hold", 1, 1'b0);
    cyc(1);    chk("cd_0_done", 0, 1'b1);
    cyc(1);    chk("cd_done_once", 0, 1'b0);
    cyc(3000); chk("cd_zero_hold", 0, 1'b0);

    // FINISH then back to SET keeps 0.
    bus.mode = MODE_FINISH;
    cyc(5);
    bus.mode = MODE_SET;
    cyc(1);    chk("finish_to_set", 0, 1'b0);

    // Stop/resume with a discarded partial second.
    pulse_u();
    bus.mode = MODE_RUN;
    cyc(5000); chk("sr_5", 5, 1'b0);
    cyc(600);  chk("sr_600", 5, 1'b0);
    bus.mode = MODE_STOP;
    cyc(1);
    bus.btnU = 1'b1;
    cyc(1);    chk("stop_btn", 5, 1'b0);
    bus.btnU = 1'b0;
    cyc(2000); chk("stop_hold", 5, 1'b0);
    bus.mode = MODE_RUN;
    cyc(999);  chk("resume_wait", 5, 1'b0);
    cyc(1);    chk("resume_dec", 4, 1'b0);

    // Reset mid-countdown at 37.
    bus.mode = MODE_IDLE;
    cyc(1);
    bus.mode = MODE_SET;
    cyc(1);
    for (int i = 0; i < 4; i++) pulse_u();
    bus.mode = MODE_RUN;
    cyc(3000); chk("pre_reset_37", 37, 1'b0);
    cyc(500);
    reset = 1'b1;
    #1;
    chk("reset_async", 0, 1'b0);
    cyc(2);
    reset = 1'b0;
    cyc(1500); chk("post_reset_run", 0, 1'b0);

    // IDLE clears 30 in one cycle.
    bus.mode = MODE_SET;
    cyc(1);
    for (int i = 0; i < 3; i++) pulse_u();
    chk("pre_idle_30", 30, 1'b0);
    bus.mode = MODE_IDLE;
    cyc(1);    chk("idle_clear", 0, 1'b0);

    // Illegal mode code behaves as IDLE.
    bus.mode = MODE_SET;
    cyc(1);
    pulse_u();
    bus.mode = 3'b111;
    cyc(1);    chk("illegal_mode", 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
